// File: rtl/operand_fetch.sv
// Single-entry operand fetch stage between decode and execute, with a backpressure counter.
// Define OPERAND_FETCH_BYPASS_EN to forward register-file writes into captured and held operands.
module operand_fetch #(
  parameter int REG_SIZE = 32,
  parameter int REG_NUM  = 32,
  localparam int A       = $clog2(REG_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [A-1:0]        in_rs1,
  input  logic [A-1:0]        in_rs2,
  input  logic [A-1:0]        in_rd,
  input  logic [REG_SIZE-1:0] in_pc,
  output logic [A-1:0]        rd_addr0,
  output logic [A-1:0]        rd_addr1,
  input  logic [REG_SIZE-1:0] rd_data0,
  input  logic [REG_SIZE-1:0] rd_data1,
  input  logic                wr_ena,
  input  logic [A-1:0]        wr_addr,
  input  logic [REG_SIZE-1:0] wr_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_SIZE-1:0] out_rs1_val,
  output logic [REG_SIZE-1:0] out_rs2_val,
  output logic [A-1:0]        out_rd,
  output logic [REG_SIZE-1:0] out_pc,
  output logic [REG_SIZE-1:0] stall_cycles
);

  logic                out_valid_q, out_valid_d;
  logic [REG_SIZE-1:0] rs1_val_q, rs1_val_d;
  logic [REG_SIZE-1:0] rs2_val_q, rs2_val_d;
  logic [A-1:0]        rd_q, rd_d;
  logic [REG_SIZE-1:0] pc_q, pc_d;
  logic [REG_SIZE-1:0] stall_q, stall_d;
  logic [REG_SIZE-1:0] op0, op1;
  logic                accept, consume;

  assign rd_addr0 = in_rs1;
  assign rd_addr1 = in_rs2;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic [A-1:0] rs1_q, rs1_d;
  logic [A-1:0] rs2_q, rs2_d;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_ena, wr_addr, wr_data};
`endif

  // Register zero always reads as zero, even if a write to it is snooped.
  always_comb begin
    op0 = rd_data0;
    op1 = rd_data1;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (wr_ena && (wr_addr == in_rs1)) op0 = wr_data;
    if (wr_ena && (wr_addr == in_rs2)) op1 = wr_data;
`endif
    if (in_rs1 == '0) op0 = '0;
    if (in_rs2 == '0) op1 = '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
`ifdef OPERAND_FETCH_BYPASS_EN
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
`endif
    if (accept) begin
      rs1_val_d = op0;
      rs2_val_d = op1;
      rd_d      = in_rd;
      pc_d      = in_pc;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
    end else if (out_valid_q && !out_ready && wr_ena) begin
      if ((rs1_q != '0) && (wr_addr == rs1_q)) rs1_val_d = wr_data;
      if ((rs2_q != '0) && (wr_addr == rs2_q)) rs2_val_d = wr_data;
`endif
    end
    if (flush)        out_valid_d = 1'b0;
    else if (accept)  out_valid_d = 1'b1;
    else if (consume) out_valid_d = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      stall_q     <= '0;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs1_q       <= '0;
      rs2_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      stall_q     <= stall_d;
`ifdef OPERAND_FETCH_BYPASS_EN
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_val  = rs1_val_q;
  assign out_rs2_val  = rs2_val_q;
  assign out_rd       = rd_q;
  assign out_pc       = pc_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed transactions push expectations, a monitor pops them on handshake.
// Expectations follow OPERAND_FETCH_BYPASS_EN when it is defined for the build.
module tb_operand_fetch;
  localparam int RS = 32;
  localparam int A  = 5;
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [A-1:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [RS-1:0] in_pc = '0;
  logic [A-1:0]  rd_addr0, rd_addr1;
  logic [RS-1:0] rd_data0 = '0, rd_data1 = '0;
  logic          wr_ena = 1'b0;
  logic [A-1:0]  wr_addr = '0;
  logic [RS-1:0] wr_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RS-1:0] out_rs1_val, out_rs2_val, out_pc, stall_cycles;
  logic [A-1:0]  out_rd;

  typedef struct {
    logic [RS-1:0] rs1;
    logic [RS-1:0] rs2;
    logic [A-1:0]  rd;
    logic [RS-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  operand_fetch #(.REG_SIZE(RS), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_pc(in_pc),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_pc(out_pc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [RS-1:0] got, input logic [RS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [A-1:0] rs1, input logic [A-1:0] rs2,
                               input logic [A-1:0] rd, input logic [RS-1:0] pc,
                               input logic [RS-1:0] d0, input logic [RS-1:0] d1);
    in_valid = v;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_pc    = pc;
    rd_data0 = d0;
    rd_data1 = d1;
  endtask

  task automatic pushExp(input logic [RS-1:0] r1, input logic [RS-1:0] r2, input logic [A-1:0] rd,
                         input logic [RS-1:0] pc);
    exp_t e;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the output side retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          checkOutput("out_rs1_val", out_rs1_val, e.rs1);
          checkOutput("out_rs2_val", out_rs2_val, e.rs2);
          checkOutput("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
          checkOutput("out_pc", out_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #3;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_stall", stall_cycles, 32'd0);
    checkOutput("reset_out_pc", out_pc, 32'd0);
    #9 rst = 1'b1;
    step();

    // Basic capture and combinational read addresses.
    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 32'h100, 32'h11, 32'h22);
    #1;
    checkOutput("rd_addr0", {27'd0, rd_addr0}, 32'd5);
    checkOutput("rd_addr1", {27'd0, rd_addr1}, 32'd6);
    pushExp(32'h11, 32'h22, 5'd7, 32'h100);
    step();
    checkOutput("latency_out_valid", {31'd0, out_valid}, 32'd1);

    // Index zero reads as zero even with a snooped write to r0.
    applyStimulus(1'b1, 5'd0, 5'd2, 5'd1, 32'h104, 32'hDEADBEEF, 32'h33);
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h7;
    pushExp(32'h0, 32'h33, 5'd1, 32'h104);
    step();

    // Accept-time bypass on rs1, then on rs2.
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd2, 32'h108, 32'h1, 32'h44);
    wr_addr = 5'd3; wr_data = 32'h99;
    pushExp(BYP ? 32'h99 : 32'h1, 32'h0, 5'd2, 32'h108);
    step();
    applyStimulus(1'b1, 5'd8, 5'd9, 5'd3, 32'h10C, 32'h10, 32'h20);
    wr_addr = 5'd9; wr_data = 32'hABC;
    pushExp(32'h10, BYP ? 32'hABC : 32'h20, 5'd3, 32'h10C);
    step();
    wr_ena = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Hold an entry for three cycles with a write to its rs2 in the second.
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd4, 5'd9, 32'h200, 32'hA, 32'hB);
    pushExp(32'hA, BYP ? 32'h55 : 32'hB, 5'd9, 32'h200);
    step();
    applyStimulus(1'b0, 5'd1, 5'd4, 5'd0, 32'h0, 32'hEE, 32'h77);
    step();
    checkOutput("hold_rs2_stable", out_rs2_val, 32'hB);
    wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    step();
    wr_ena = 1'b0;
    checkOutput("hold_rs2_bypass", out_rs2_val, BYP ? 32'h55 : 32'hB);
    checkOutput("hold_rs1_stable", out_rs1_val, 32'hA);
    step();
    checkOutput("stall_cycles_3", stall_cycles, 32'd3);
    checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    checkOutput("stall_after_consume", stall_cycles, 32'd3);

    // Back-to-back accepts with no bubble, then flush overriding an accept.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd10, 5'd11, 5'd5, 32'(i * 4), 32'(i + 1), 32'(i + 2));
      pushExp(32'(i + 1), 32'(i + 2), 5'd5, 32'(i * 4));
      step();
      checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    end
    applyStimulus(1'b1, 5'd10, 5'd11, 5'd5, 32'hC, 32'h5, 32'h6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_accept_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush discards a held entry.
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd12, 5'd13, 5'd6, 32'h20, 32'h1, 32'h2);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    checkOutput("flush_held_out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stall.
    applyStimulus(1'b1, 5'd14, 5'd15, 5'd8, 32'h300, 32'h3, 32'h4);
    step();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    #1 rst = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_stall", stall_cycles, 32'd0);
    checkOutput("async_rst_rs1_val", out_rs1_val, 32'd0);
    checkOutput("async_rst_out_pc", out_pc, 32'd0);
    #10 rst = 1'b1;
    step();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32, operand/data width in bits.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers; A = $clog2(REG_NUM) below.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: upstream (decode) handshake.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  A each: source and destination register indices.
REQ-007 SHALL have port in_pc  input  REG_SIZE: payload passed through unchanged.
REQ-008 SHALL have ports rd_addr0, rd_addr1  output  A: read addresses to the register file.
REQ-009 SHALL have ports rd_data0, rd_data1  input  REG_SIZE: combinational read data from the register file.
REQ-010 SHALL have ports wr_ena input 1, wr_addr input A, wr_data input REG_SIZE: snoop of the register file write port.
REQ-011 SHALL have port flush  input  1: synchronous discard of the held entry.
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1: downstream (execute) handshake.
REQ-013 SHALL have ports out_rs1_val, out_rs2_val output REG_SIZE; out_rd output A; out_pc output REG_SIZE.
REQ-014 SHALL have port stall_cycles  output  REG_SIZE: backpressure cycle counter.

Function
REQ-015 SHALL be a single-entry registered stage; all out_* ports driven from flops.
REQ-016 SHALL drive rd_addr0 = in_rs1 and rd_addr1 = in_rs2 combinationally, every cycle.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational); accept occurs when in_valid && in_ready.
REQ-018 On accept, SHALL capture operand values, in_rd and in_pc; out_valid = 1 the next cycle (latency 1).
REQ-019 Operand for index 0 SHALL be captured as 0 regardless of rd_data or bypass.
REQ-020 On out_valid && out_ready with no accept the same cycle, out_valid SHALL clear next edge.
REQ-021 Simultaneous consume and accept SHALL replace the entry with no bubble (full throughput, one per cycle).
REQ-022 flush SHALL clear out_valid next edge, overriding a same-cycle accept; in_ready is unaffected by flush.
REQ-023 Held outputs SHALL remain stable while out_valid && !out_ready (except REQ-026 update).
REQ-024 stall_cycles SHALL increment each cycle out_valid && !out_ready, saturating at all-ones; cleared only by reset.

Reset
REQ-025 While rst is low: out_valid = 0, out_rs1_val = out_rs2_val = 0, out_rd = 0, out_pc = 0, stall_cycles = 0, asynchronously; in_ready = 1 follows from out_valid = 0.

Configuration
REQ-026 With macro OPERAND_FETCH_BYPASS_EN defined: on accept, an operand whose nonzero index equals wr_addr with wr_ena = 1 SHALL capture wr_data instead of rd_data; while an entry is held (out_valid, not consumed), a held operand whose nonzero source index equals wr_addr with wr_ena = 1 SHALL be overwritten with wr_data at that edge.
REQ-027 Without OPERAND_FETCH_BYPASS_EN: operands SHALL be rd_data only (0 for index 0); wr_* ports are ignored and held operands never change.

Verification
REQ-028 Reset then in_valid=1, rs1=5, rs2=6, rd_data0=0x11, rd_data1=0x22, out_ready=1 -> next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22.
REQ-029 rs1=0, rd_data0=0xDEADBEEF, wr_ena=1, wr_addr=0, wr_data=7 -> out_rs1_val=0 (both configs).
REQ-030 Accept rs1=3, rd_data0=1, wr_ena=1, wr_addr=3, wr_data=0x99 -> out_rs1_val=0x99 with BYPASS_EN, 1 without.
REQ-031 Hold entry (rs2=4) with out_ready=0 for 3 cycles, wr_addr=4 wr_data=0x55 in cycle 2 -> out_rs2_val=0x55 from cycle 3 (BYPASS_EN), stall_cycles=3.
REQ-032 Back-to-back accepts, out_ready=1, pc=0x0,0x4,0x8 -> out_pc 0x0,0x4,0x8 on consecutive cycles, no bubble; flush with in_valid=1 -> out_valid=0 next cycle.
REQ-033 Assert rst low while out_valid=1 mid-stall -> out_valid, stall_cycles = 0 immediately, before next clk edge.
